// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//   EX/MEM pipeline register of a 5-stage MIPS-style pipeline. Captures the
//   EX-stage result and control bits one cycle later, resolves the branch
//   decision (out_pc_src) and keeps a saturating count of taken branches.
//
//   Per-edge priority: reset > flush > stall > load.
//
// Configuration macro:
//   EX_MEM_BNE_EN - when defined, branch_ne also produces a taken branch when
//                   alu_zero is low. When undefined, branch_ne is ignored.
//
// Parameters:
//   CNT_W          width of the taken-branch counter (default 16)
//
// Ports:
//   clk            single clock, rising edge
//   reset          synchronous, active-high reset
//   stall          hold all registered state
//   flush          replace the captured instruction with a bubble
//   in_valid       EX-stage instruction is valid
//   alu_out        ALU result (passed bit-exact)
//   alu_zero       high when alu_out == 0
//   write_data     rt value for a store
//   write_reg      destination register number
//   reg_write, mem_write, mem_to_reg, branch, branch_ne  decoded control
//   pc_branch      branch target address
//   out_*          registered copies of the above for the MEM stage
//   out_pc_src     registered branch-taken decision
//   br_count       saturating count of taken branches
// ---------------------------------------------------------------------------
module ex_mem_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      alu_out,
  input  logic             alu_zero,
  input  logic [31:0]      write_data,
  input  logic [4:0]       write_reg,
  input  logic             reg_write,
  input  logic             mem_write,
  input  logic             mem_to_reg,
  input  logic             branch,
  input  logic             branch_ne,
  input  logic [31:0]      pc_branch,
  output logic             out_valid,
  output logic             out_reg_write,
  output logic             out_mem_write,
  output logic             out_mem_to_reg,
  output logic             out_pc_src,
  output logic [31:0]      out_alu_result,
  output logic [31:0]      out_write_data,
  output logic [31:0]      out_pc_branch,
  output logic [4:0]       out_write_reg,
  output logic [CNT_W-1:0] br_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             w_taken;
  logic             r_valid;
  logic             r_reg_write;
  logic             r_mem_write;
  logic             r_mem_to_reg;
  logic             r_pc_src;
  logic [31:0]      r_alu_result;
  logic [31:0]      r_write_data;
  logic [31:0]      r_pc_branch;
  logic [4:0]       r_write_reg;
  logic [CNT_W-1:0] r_br_count;

`ifndef EX_MEM_BNE_EN
  // branch_ne stays on the port list so both builds share one interface.
  logic w_unused_branch_ne;
  assign w_unused_branch_ne = branch_ne;
`endif

  // Branch decision for the instruction currently in EX.
  always_comb begin
    w_taken = 1'b0;
`ifdef EX_MEM_BNE_EN
    w_taken = in_valid & ((branch & alu_zero) | (branch_ne & ~alu_zero));
`else
    w_taken = in_valid & branch & alu_zero;
`endif
  end

  // Pipeline register and taken-branch counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_pc_src     <= 1'b0;
      r_alu_result <= 32'h0000_0000;
      r_write_data <= 32'h0000_0000;
      r_pc_branch  <= 32'h0000_0000;
      r_write_reg  <= 5'd0;
      r_br_count   <= {CNT_W{1'b0}};
    end else if (flush) begin
      // Bubble: only the control bits are cleared; data is left as-is
      // because nothing downstream consumes it while out_valid is low.
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_pc_src     <= 1'b0;
    end else if (stall) begin
      r_valid      <= r_valid;
      r_br_count   <= r_br_count;
    end else begin
      r_valid      <= in_valid;
      // An invalid slot must never write the register file or memory.
      r_reg_write  <= reg_write & in_valid;
      r_mem_write  <= mem_write & in_valid;
      r_mem_to_reg <= mem_to_reg;
      r_pc_src     <= w_taken;
      r_alu_result <= alu_out;
      r_write_data <= write_data;
      r_pc_branch  <= pc_branch;
      r_write_reg  <= write_reg;
      if (w_taken && (r_br_count != CNT_MAX)) begin
        r_br_count <= r_br_count + CNT_ONE;
      end else begin
        r_br_count <= r_br_count;
      end
    end
  end

  assign out_valid      = r_valid;
  assign out_reg_write  = r_reg_write;
  assign out_mem_write  = r_mem_write;
  assign out_mem_to_reg = r_mem_to_reg;
  assign out_pc_src     = r_pc_src;
  assign out_alu_result = r_alu_result;
  assign out_write_data = r_write_data;
  assign out_pc_branch  = r_pc_branch;
  assign out_write_reg  = r_write_reg;
  assign br_count       = r_br_count;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
//   Directed bench for ex_mem_stage. Two instances share the stimulus: one
//   with the default counter width and one with CNT_W=4 for saturation.
//   Each step drives inputs, pushes the expected register contents (from a
//   small behavioural model) to a scoreboard queue, clocks once and pops
//   and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid, alu_zero;
  logic [31:0] alu_out, write_data, pc_branch;
  logic [4:0]  write_reg;
  logic        reg_write, mem_write, mem_to_reg, branch, branch_ne;

  logic        out_valid, out_reg_write, out_mem_write, out_mem_to_reg, out_pc_src;
  logic [31:0] out_alu_result, out_write_data, out_pc_branch;
  logic [4:0]  out_write_reg;
  logic [15:0] br_count;

  logic        s_valid, s_reg_write, s_mem_write, s_mem_to_reg, s_pc_src;
  logic [31:0] s_alu_result, s_write_data, s_pc_branch;
  logic [4:0]  s_write_reg;
  logic [3:0]  s_br_count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        v, rw, mw, m2r, pcs;
    logic [4:0]  wr;
    logic [31:0] alu, wd, pcb;
    logic        dk;   // data fields are defined (not after a flush)
    logic [15:0] cnt;
    logic [3:0]  sat;
  } exp_t;

  exp_t m;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  ex_mem_stage u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_out(alu_out), .alu_zero(alu_zero), .write_data(write_data),
    .write_reg(write_reg), .reg_write(reg_write), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .branch(branch), .branch_ne(branch_ne),
    .pc_branch(pc_branch), .out_valid(out_valid), .out_reg_write(out_reg_write),
    .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
    .out_pc_src(out_pc_src), .out_alu_result(out_alu_result),
    .out_write_data(out_write_data), .out_pc_branch(out_pc_branch),
    .out_write_reg(out_write_reg), .br_count(br_count)
  );

  ex_mem_stage #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_out(alu_out), .alu_zero(alu_zero), .write_data(write_data),
    .write_reg(write_reg), .reg_write(reg_write), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .branch(branch), .branch_ne(branch_ne),
    .pc_branch(pc_branch), .out_valid(s_valid), .out_reg_write(s_reg_write),
    .out_mem_write(s_mem_write), .out_mem_to_reg(s_mem_to_reg),
    .out_pc_src(s_pc_src), .out_alu_result(s_alu_result),
    .out_write_data(s_write_data), .out_pc_branch(s_pc_branch),
    .out_write_reg(s_write_reg), .br_count(s_br_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    alu_out = 32'h0; alu_zero = 1'b0; write_data = 32'h0; write_reg = 5'd0;
    reg_write = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
    branch = 1'b0; branch_ne = 1'b0; pc_branch = 32'h0;
  endtask

  // Advance the reference model by one edge using the current inputs,
  // push the expectation, clock, then pop and compare.
  task automatic step(input string tag);
    logic tk;
    exp_t e;
    tk = in_valid & branch & alu_zero;
`ifdef EX_MEM_BNE_EN
    tk = tk | (in_valid & branch_ne & ~alu_zero);
`endif
    if (reset) begin
      m = '0;
      m.dk = 1'b1;
    end else if (flush) begin
      m.v = 1'b0; m.rw = 1'b0; m.mw = 1'b0; m.m2r = 1'b0; m.pcs = 1'b0;
      m.dk = 1'b0;
    end else if (!stall) begin
      m.v = in_valid; m.rw = reg_write & in_valid; m.mw = mem_write & in_valid;
      m.m2r = mem_to_reg; m.pcs = tk; m.wr = write_reg; m.alu = alu_out;
      m.wd = write_data; m.pcb = pc_branch; m.dk = 1'b1;
      if (tk && m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
      if (tk && m.sat != 4'hF) m.sat = m.sat + 4'd1;
    end
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, e.v});
    chk({tag, ".reg_write"}, {31'd0, out_reg_write}, {31'd0, e.rw});
    chk({tag, ".mem_write"}, {31'd0, out_mem_write}, {31'd0, e.mw});
    chk({tag, ".mem_to_reg"}, {31'd0, out_mem_to_reg}, {31'd0, e.m2r});
    chk({tag, ".pc_src"}, {31'd0, out_pc_src}, {31'd0, e.pcs});
    chk({tag, ".br_count"}, {16'd0, br_count}, {16'd0, e.cnt});
    chk({tag, ".sat_count"}, {28'd0, s_br_count}, {28'd0, e.sat});
    chk({tag, ".sat_pc_src"}, {31'd0, s_pc_src}, {31'd0, e.pcs});
    if (e.dk) begin
      chk({tag, ".write_reg"}, {27'd0, out_write_reg}, {27'd0, e.wr});
      chk({tag, ".alu_result"}, out_alu_result, e.alu);
      chk({tag, ".write_data"}, out_write_data, e.wd);
      chk({tag, ".pc_branch"}, out_pc_branch, e.pcb);
    end
  endtask

  initial begin
    m = '0;
    idle_inputs();

    // Reset, including a simultaneous taken branch that must not count.
    reset = 1'b1; in_valid = 1'b1; branch = 1'b1; alu_zero = 1'b1;
    step("reset0");
    idle_inputs(); reset = 1'b1;
    step("reset1");

    // Plain load.
    idle_inputs();
    in_valid = 1'b1; alu_out = 32'h0000_002A; write_reg = 5'd5; reg_write = 1'b1;
    step("load");
    chk("load.const_alu", out_alu_result, 32'h0000_002A);
    chk("load.const_wr", {27'd0, out_write_reg}, 32'd5);

    // beq taken.
    idle_inputs();
    in_valid = 1'b1; branch = 1'b1; alu_zero = 1'b1; pc_branch = 32'h0040_0020;
    step("beq_taken");
    chk("beq.const_pcb", out_pc_branch, 32'h0040_0020);
    chk("beq.const_cnt", {16'd0, br_count}, 32'd1);

    // beq not taken, store, invalid slot, negative value bit-exact.
    idle_inputs();
    in_valid = 1'b1; branch = 1'b1; alu_zero = 1'b0; pc_branch = 32'h0040_0100;
    alu_out = 32'hFFFF_FFFC;
    step("beq_not_taken");
    idle_inputs();
    in_valid = 1'b1; mem_write = 1'b1; write_data = 32'hDEAD_BEEF; alu_out = 32'h1000_0008;
    step("store");
    idle_inputs();
    reg_write = 1'b1; mem_write = 1'b1; mem_to_reg = 1'b1; branch = 1'b1;
    alu_zero = 1'b1; write_reg = 5'd31; alu_out = 32'h0000_0000;
    step("invalid_slot");
    idle_inputs();
    in_valid = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1;
    alu_out = 32'h8000_0001; write_reg = 5'd17;
    step("neg_bitexact");

    // Stall 3 cycles with a taken branch presented: everything frozen.
    idle_inputs();
    stall = 1'b1; in_valid = 1'b1; branch = 1'b1; alu_zero = 1'b1;
    alu_out = 32'h1234_5678; write_reg = 5'd9; pc_branch = 32'h0000_0040;
    for (int i = 0; i < 3; i++) step("stall");

    // Flush with stall: bubble, counter unchanged.
    flush = 1'b1; reg_write = 1'b1;
    step("flush_stall");
    chk("flush.const_cnt", {16'd0, br_count}, 32'd1);

    // Load resumes.
    idle_inputs();
    in_valid = 1'b1; reg_write = 1'b1; alu_out = 32'h0000_0077; write_reg = 5'd3;
    step("resume");

    // bne: taken only when the optional feature is built in.
    idle_inputs();
    in_valid = 1'b1; branch_ne = 1'b1; alu_zero = 1'b0; pc_branch = 32'h0040_0200;
    step("bne");
`ifdef EX_MEM_BNE_EN
    chk("bne.const_pcs", {31'd0, out_pc_src}, 32'd1);
`else
    chk("bne.const_pcs", {31'd0, out_pc_src}, 32'd0);
`endif

    // Saturation: clear, then 17 consecutive taken branches, then one more.
    idle_inputs(); reset = 1'b1;
    step("sat_reset");
    idle_inputs();
    in_valid = 1'b1; branch = 1'b1; alu_zero = 1'b1;
    for (int i = 0; i < 18; i++) begin
      pc_branch = 32'h0040_0000 + 32'(i * 4);
      step("sat");
    end
    chk("sat.const_sat", {28'd0, s_br_count}, 32'hF);
    chk("sat.const_cnt", {16'd0, br_count}, 32'd18);

    // Reset mid-operation together with load, flush and stall.
    reset = 1'b1; flush = 1'b1; stall = 1'b1; reg_write = 1'b1; mem_write = 1'b1;
    alu_out = 32'hCAFE_F00D; write_reg = 5'd12;
    step("reset_mid");
    idle_inputs();
    in_valid = 1'b1; reg_write = 1'b1; alu_out = 32'h0000_0055; write_reg = 5'd8;
    branch = 1'b1; alu_zero = 1'b1;
    step("post_reset_load");
    chk("post_reset.const_cnt", {16'd0, br_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning width of the taken-branch counter.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  hold all registered state.
REQ-005 SHALL have port flush  input  1  replace the captured instruction with a bubble.
REQ-006 SHALL have port in_valid  input  1  EX-stage instruction is valid.
REQ-007 SHALL have port alu_out  input  32  ALU result, signed.
REQ-008 SHALL have port alu_zero  input  1  high when alu_out == 0.
REQ-009 SHALL have port write_data  input  32  rt value for store.
REQ-010 SHALL have port write_reg  input  5  destination register number.
REQ-011 SHALL have ports reg_write, mem_write, mem_to_reg, branch, branch_ne  input  1 each  decoded control bits.
REQ-012 SHALL have port pc_branch  input  32  branch target address.
REQ-013 SHALL have ports out_valid, out_reg_write, out_mem_write, out_mem_to_reg, out_pc_src  output  1 each  registered.
REQ-014 SHALL have ports out_alu_result, out_write_data, out_pc_branch  output  32 each  registered.
REQ-015 SHALL have port out_write_reg  output  5  registered.
REQ-016 SHALL have port br_count  output  CNT_W  count of taken branches.

Function
REQ-017 SHALL use one cycle of latency: inputs sampled at edge N appear on outputs after edge N.
REQ-018 SHALL apply per-edge priority: reset > flush > stall > load.
REQ-019 SHALL, on load, capture every input into the corresponding out_* register and set out_valid = in_valid.
REQ-020 SHALL gate out_reg_write and out_mem_write with in_valid at capture, so an invalid slot never writes.
REQ-021 SHALL compute taken = in_valid & branch & alu_zero (beq) at capture and register it as out_pc_src.
REQ-022 SHALL, on flush, clear out_valid, out_reg_write, out_mem_write, out_mem_to_reg and out_pc_src; data registers may hold any value.
REQ-023 SHALL, on stall without flush, hold every output and br_count unchanged.
REQ-024 SHALL increment br_count by 1 only on a load edge whose taken = 1.
REQ-025 SHALL saturate br_count at all-ones; it never wraps.
REQ-026 SHALL NOT increment br_count on flush, stall or reset edges.
REQ-027 SHALL pass alu_out bit-exact, with no sign or width change.

Reset
REQ-028 SHALL, on reset, drive every output including br_count to 0.
REQ-029 SHALL let reset override a simultaneous flush, stall or load on the same edge.
REQ-030 SHALL resume normal loading on the first edge after reset deasserts.

Configuration
REQ-031 SHALL recognise macro EX_MEM_BNE_EN.
REQ-032 SHALL, when EX_MEM_BNE_EN is defined, compute taken = in_valid & ((branch & alu_zero) | (branch_ne & ~alu_zero)).
REQ-033 SHALL, when EX_MEM_BNE_EN is undefined, keep port branch_ne present but ignore it, with taken per REQ-021.

Verification
REQ-034 SHALL cover load: in_valid=1, alu_out=0x0000002A, write_reg=5, reg_write=1 -> next cycle out_alu_result=0x2A, out_write_reg=5, out_reg_write=1, out_valid=1.
REQ-035 SHALL cover beq taken: branch=1, alu_zero=1, pc_branch=0x00400020 -> out_pc_src=1, out_pc_branch=0x00400020, br_count increments 0->1.
REQ-036 SHALL cover stall and flush: stall=1 for 3 cycles -> outputs frozen; then flush=1 with stall=1 -> out_valid=0, out_reg_write=0, out_pc_src=0, br_count unchanged.
REQ-037 SHALL cover saturation: CNT_W=4, 17 consecutive taken branches -> br_count reaches 0xF and stays 0xF.
REQ-038 SHALL cover bne: branch_ne=1, alu_zero=0 -> out_pc_src=1 with EX_MEM_BNE_EN defined, 0 without it.
REQ-039 SHALL cover reset mid-operation: reset=1 together with load and flush -> all outputs 0 next cycle; load resumes the cycle after reset deasserts.
